io_ctrl: RTL and testbench
==========================

# io_ctrl

Memory-mapped I/O controller directly downstream of the CPU's external memory bus (`mem_a`/`mem_dout`/`mem_wr`). It claims accesses with `mem_a[17:16]==2'b11`, buffers UART TX bytes in a FIFO and drives `io_buffer_full` back to the CPU. It also provides the cycle counter and program-stop ports, optionally buffers UART RX bytes, and muxes I/O read data with RAM read data onto the CPU's `mem_din`.

## Interface
- `TX_AW`, 4: log2 of TX FIFO depth (16 entries).
- `RX_AW`, 4: log2 of RX FIFO depth; used only with `IO_RX_EN`.
- `FULL_MARGIN`, 2: `io_buffer_full` asserts when TX free slots ≤ this value.
- `clk_in` in 1: the single clock.
- `rst_in` in 1: synchronous, active-low reset.
- `rdy_in` in 1: bus accesses are ignored while low; the counter and TX drain keep running.
- `mem_a` in 32: CPU address.
- `mem_dout` in 8: CPU write data.
- `mem_wr` in 1: CPU write strobe (1 = write).
- `ram_din` in 8: RAM read data, one-cycle latency.
- `ram_wr` out 1: `mem_wr & rdy_in & ~io_hit`, combinational; RAM writes are suppressed for I/O addresses.
- `mem_din` out 8: read data to CPU; `io_sel_q ? io_rdata_q : ram_din`.
- `io_buffer_full` out 1: TX near-full indication to the CPU.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: UART TX stream; a byte transfers on `tx_valid & tx_ready`.
- `rx_data` in 8, `rx_valid` in 1: UART RX byte pulse (`IO_RX_EN` only).
- `program_stop` out 1: sticky end-of-program flag.

## Operation
- Decode: `io_hit = rdy_in & (mem_a[17:16]==2'b11)`. Offsets are taken from `mem_a[2:0]`.
- Write to 0x30000: push `mem_dout` into the TX FIFO. A data byte of 0x00 is ignored.
- Write to 0x30004: set `stop_req` and push 0x00 into the TX FIFO.
- Write to any other I/O offset: no effect.
- Read 0x30000: pop the RX FIFO head into `io_rdata_q`. If RX is empty, or `IO_RX_EN` is off, return 0x00.
- Read 0x30004: snapshot the 32-bit cycle counter into `cnt_snap` and return byte 0.
- Reads of 0x30005–0x30007: return `cnt_snap` bytes 1–3 (little-endian), giving a coherent 4-byte read.
- Reads of other I/O offsets return 0x00.
- Cycle counter: 32-bit. Cleared by reset, then +1 every clock regardless of `rdy_in`. Wraps 0xFFFFFFFF→0.
- TX FIFO: circular buffer with `TX_AW`+1-bit pointers. `tx_valid = ~empty`; `tx_data` = head entry.
- Push to a full TX FIFO with no simultaneous pop: the byte is dropped and the FIFO is unchanged.
- Push to a full TX FIFO with a simultaneous pop: the push is accepted.
- Push and pop in the same cycle on a non-full FIFO: the count is unchanged.
- `io_buffer_full` is registered: `free_next ≤ FULL_MARGIN`.
- `program_stop` asserts the cycle after `stop_req` is set and the TX FIFO is empty (the 0x00 has been sent). It stays high until reset.
- RX FIFO (`IO_RX_EN`): `rx_valid` pushes `rx_data`. A push to a full RX FIFO is dropped. Push and pop in the same cycle are both honoured.

## Timing
- Reset values: `mem_din` selects RAM (`io_sel_q`=0, `io_rdata_q`=0); `tx_valid`=0; `io_buffer_full`=0; `program_stop`=0; counter=0; `cnt_snap`=0; both FIFOs empty; `stop_req`=0.
- Reset mid-transfer discards all FIFO contents; there is no partial recovery.
- Read latency is 1 cycle. Access in cycle N → `io_sel_q`/`io_rdata_q` valid in N+1, aligned with `ram_din`.
- `io_sel_q` updates only when `rdy_in` is high. While `rdy_in` is low, `mem_din` holds its previous selection.
- A TX write in cycle N makes `tx_valid` high in N+1 (FIFO was empty).
- `io_buffer_full` reflects a push/pop one cycle after it occurs. `FULL_MARGIN` absorbs stores in flight.
- Counter value read at 0x30004 in cycle N equals cycles elapsed since reset release, sampled at edge N.

## Configuration
- `IO_RX_EN` defined: RX FIFO and `rx_data`/`rx_valid` are active, and 0x30000 reads pop it.
- `IO_RX_EN` undefined: no RX storage is built, `rx_*` inputs are ignored, and 0x30000 reads return 0x00.

## Test plan
- Write 0x41, 0x00, 0x42 to 0x30000 with `tx_ready`=1 → `tx_data` shows 0x41 then 0x42, and 0x00 never appears.
- Hold `tx_ready`=0 and write 14 bytes → `io_buffer_full` rises the cycle after the 14th push. The 17th write is dropped, and draining yields the 16 original bytes in order.
- Release reset, wait 100 cycles, read 0x30004–0x30007 → bytes form 0x00000064 (±issue offset, checked against the model), and the bytes stay coherent even though the counter advances during the reads.
- Write 0x30004 with 3 bytes queued and `tx_ready`=1 → the 3 bytes are sent, then 0x00, and `program_stop` rises one cycle after the FIFO empties and stays high.
- `IO_RX_EN`: pulse `rx_valid` with 0x55, read 0x30000 → `mem_din`=0x55 next cycle. A second read returns 0x00.
- Access 0x30000 with `rdy_in`=0 → no push/pop and `ram_wr`=0. A RAM read at 0x00010 returns `ram_din` unchanged.

Source files
------------

// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller: TX FIFO, cycle counter, program stop and read-data mux.
// Define IO_RX_EN to build the RX FIFO that 0x30000 reads pop.
module io_ctrl #(
    parameter int TX_AW       = 4,
    parameter int RX_AW       = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    input  logic [7:0]  ram_din,
    output logic        ram_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_stop
);

    localparam int             TX_DEPTH    = 1 << TX_AW;
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [TX_AW:0] TX_MARGIN   = (TX_AW + 1)'(FULL_MARGIN);
    localparam logic [TX_AW:0] TX_ONE      = (TX_AW + 1)'(1);
    localparam logic [2:0]     OFF_DATA    = 3'd0;
    localparam logic [2:0]     OFF_CNT0    = 3'd4;
    localparam logic [2:0]     OFF_CNT1    = 3'd5;
    localparam logic [2:0]     OFF_CNT2    = 3'd6;
    localparam logic [2:0]     OFF_CNT3    = 3'd7;

    logic             io_hit;
    logic [2:0]       io_off;
    logic             rd_hit;
    logic             wr_data;
    logic             wr_stop;
    logic             tx_push;
    logic [7:0]       tx_push_byte;
    logic [TX_AW:0]   tx_cnt;
    logic             tx_empty;
    logic             tx_full;
    logic             tx_pop;
    logic             tx_push_ok;
    logic [TX_AW:0]   tx_cnt_next;
    logic [TX_AW:0]   tx_free_next;
    logic [7:0]       rx_byte;
    logic             unused_bits;

    logic [TX_AW:0]   tx_wptr_q, tx_wptr_d;
    logic [TX_AW:0]   tx_rptr_q, tx_rptr_d;
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [7:0]       tx_mem_d [TX_DEPTH];
    logic             io_buffer_full_q, io_buffer_full_d;
    logic             io_sel_q, io_sel_d;
    logic [7:0]       io_rdata_q, io_rdata_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      cnt_snap_q, cnt_snap_d;
    logic             stop_req_q, stop_req_d;
    logic             program_stop_q, program_stop_d;

    assign io_hit       = rdy_in & (mem_a[17:16] == 2'b11);
    assign io_off       = mem_a[2:0];
    assign rd_hit       = io_hit & ~mem_wr;
    assign ram_wr       = mem_wr & rdy_in & ~io_hit;
    assign wr_data      = io_hit & mem_wr & (io_off == OFF_DATA) & (mem_dout != 8'h00);
    assign wr_stop      = io_hit & mem_wr & (io_off == OFF_CNT0);
    assign tx_push      = wr_data | wr_stop;
    assign tx_push_byte = wr_stop ? 8'h00 : mem_dout;

    assign tx_cnt     = tx_wptr_q - tx_rptr_q;
    assign tx_empty   = (tx_cnt == '0);
    assign tx_full    = (tx_cnt == TX_FULL_CNT);
    assign tx_pop     = ~tx_empty & tx_ready;
    assign tx_push_ok = tx_push & (~tx_full | tx_pop);

    assign tx_valid       = ~tx_empty;
    assign tx_data        = tx_mem_q[tx_rptr_q[TX_AW-1:0]];
    assign io_buffer_full = io_buffer_full_q;
    assign program_stop   = program_stop_q;
    assign mem_din        = io_sel_q ? io_rdata_q : ram_din;

    // When full with a pop, the write slot equals the head slot; head is read before the edge.
    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_mem_d  = tx_mem_q;
        if (tx_push_ok) begin
            tx_mem_d[tx_wptr_q[TX_AW-1:0]] = tx_push_byte;
            tx_wptr_d = tx_wptr_q + TX_ONE;
        end
        if (tx_pop) begin
            tx_rptr_d = tx_rptr_q + TX_ONE;
        end
        tx_cnt_next      = tx_wptr_d - tx_rptr_d;
        tx_free_next     = TX_FULL_CNT - tx_cnt_next;
        io_buffer_full_d = (tx_free_next <= TX_MARGIN);
    end

`ifdef IO_RX_EN
    localparam int             RX_DEPTH    = 1 << RX_AW;
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [RX_AW:0] RX_ONE      = (RX_AW + 1)'(1);

    logic [RX_AW:0] rx_wptr_q, rx_wptr_d;
    logic [RX_AW:0] rx_rptr_q, rx_rptr_d;
    logic [7:0]     rx_mem_q [RX_DEPTH];
    logic [7:0]     rx_mem_d [RX_DEPTH];
    logic [RX_AW:0] rx_cnt;
    logic           rx_empty;
    logic           rx_full;
    logic           rx_pop;
    logic           rx_push_ok;

    assign rx_cnt     = rx_wptr_q - rx_rptr_q;
    assign rx_empty   = (rx_cnt == '0);
    assign rx_full    = (rx_cnt == RX_FULL_CNT);
    assign rx_pop     = rd_hit & (io_off == OFF_DATA) & ~rx_empty;
    assign rx_push_ok = rx_valid & ~rx_full;
    assign rx_byte    = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q[RX_AW-1:0]];

    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_mem_d  = rx_mem_q;
        if (rx_push_ok) begin
            rx_mem_d[rx_wptr_q[RX_AW-1:0]] = rx_data;
            rx_wptr_d = rx_wptr_q + RX_ONE;
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + RX_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        rx_mem_q <= rx_mem_d;
    end

    assign unused_bits = ^{mem_a[31:18], mem_a[15:3]};
`else
    localparam int RX_DEPTH_UNUSED = 1 << RX_AW;

    assign rx_byte     = 8'h00;
    assign unused_bits = ^{mem_a[31:18], mem_a[15:3], rx_data, rx_valid};
`endif

    always_comb begin
        io_rdata_d = io_rdata_q;
        if (rd_hit) begin
            case (io_off)
                OFF_DATA: io_rdata_d = rx_byte;
                OFF_CNT0: io_rdata_d = cnt_q[7:0];
                OFF_CNT1: io_rdata_d = cnt_snap_q[15:8];
                OFF_CNT2: io_rdata_d = cnt_snap_q[23:16];
                OFF_CNT3: io_rdata_d = cnt_snap_q[31:24];
                default:  io_rdata_d = 8'h00;
            endcase
        end
    end

    // Snapshot on the byte-0 read so bytes 1-3 come from the same counter value.
    always_comb begin
        io_sel_d       = rdy_in ? rd_hit : io_sel_q;
        cnt_d          = cnt_q + 32'd1;
        cnt_snap_d     = (rd_hit && (io_off == OFF_CNT0)) ? cnt_q : cnt_snap_q;
        stop_req_d     = stop_req_q | wr_stop;
        program_stop_d = program_stop_q | (stop_req_q & tx_empty);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tx_wptr_q        <= '0;
            tx_rptr_q        <= '0;
            io_buffer_full_q <= 1'b0;
            io_sel_q         <= 1'b0;
            io_rdata_q       <= 8'h00;
            cnt_q            <= 32'd0;
            cnt_snap_q       <= 32'd0;
            stop_req_q       <= 1'b0;
            program_stop_q   <= 1'b0;
        end else begin
            tx_wptr_q        <= tx_wptr_d;
            tx_rptr_q        <= tx_rptr_d;
            io_buffer_full_q <= io_buffer_full_d;
            io_sel_q         <= io_sel_d;
            io_rdata_q       <= io_rdata_d;
            cnt_q            <= cnt_d;
            cnt_snap_q       <= cnt_snap_d;
            stop_req_q       <= stop_req_d;
            program_stop_q   <= program_stop_d;
        end
    end

    always_ff @(posedge clk_in) begin
        tx_mem_q <= tx_mem_d;
    end

endmodule

// File: tb/tb_io_ctrl.sv
// Scoreboard bench for io_ctrl: TX bytes and bus read data are queued at stimulus time
// and compared when the DUT presents them.
module tb_io_ctrl;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  ram_din;
    logic        ram_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        program_stop;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tx_q [$];
    logic [7:0]  rd_q [$];
    logic        rd_drv = 1'b0;
    logic        rd_due = 1'b0;
    logic [7:0]  mon_exp;

    io_ctrl dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .ram_din        (ram_din),
        .ram_wr         (ram_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_stop   (program_stop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_due <= rd_drv;

    always @(negedge clk) begin
        if (rst_in && tx_valid && tx_ready) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got %02h expected no transfer", tx_data);
            end else begin
                mon_exp = tx_q.pop_front();
                if (tx_data !== mon_exp) begin
                    errors++;
                    $display("FAIL tx_data got %02h expected %02h", tx_data, mon_exp);
                end
            end
        end
        if (rd_due) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_scoreboard got %02h expected queued entry", mem_din);
            end else begin
                mon_exp = rd_q.pop_front();
                if (mem_din !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_data got %02h expected %02h", mem_din, mon_exp);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_io(input logic [31:0] a, input logic [7:0] d);
        mem_a    = a;
        mem_dout = d;
        mem_wr   = 1'b1;
        rd_drv   = 1'b0;
        @(posedge clk);
        #1;
        mem_wr = 1'b0;
        mem_a  = 32'h0;
    endtask

    task automatic rd_io(input logic [31:0] a, input logic [7:0] exp);
        mem_a  = a;
        mem_wr = 1'b0;
        rd_drv = 1'b1;
        rd_q.push_back(exp);
        @(posedge clk);
        #1;
        rd_drv = 1'b0;
        mem_a  = 32'h0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        step(3);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b expected 0", tx_valid); end
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b expected 0", io_buffer_full); end
        checks++; if (program_stop !== 1'b0) begin errors++; $display("FAIL reset_stop got %b expected 0", program_stop); end
        checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL reset_mem_din got %02h expected 3c", mem_din); end
        rst_in = 1'b1;
        step(1);
    endtask

    task automatic test_tx_basic();
        tx_ready = 1'b1;
        tx_q.push_back(8'h41);
        wr_io(32'h30000, 8'h41);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            errors++; $display("FAIL tx_first valid=%b data=%02h expected 1/41", tx_valid, tx_data);
        end
        wr_io(32'h30000, 8'h00);
        tx_q.push_back(8'h42);
        wr_io(32'h30000, 8'h42);
        step(4);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_basic_idle got %b expected 0", tx_valid); end
        checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL tx_basic_left got %0d expected 0", tx_q.size()); end
    endtask

    task automatic test_full_drop();
        int n;
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_q.push_back(8'h60 + 8'(i));
            wr_io(32'h30000, 8'h60 + 8'(i));
            if (i == 12) begin
                checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL full_after13 got %b expected 0", io_buffer_full); end
            end
            if (i == 13) begin
                checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL full_after14 got %b expected 1", io_buffer_full); end
            end
        end
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid && n < 40) begin
            step(1);
            n++;
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_timeout got %b expected 0", tx_valid); end
        checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL drain_left got %0d expected 0", tx_q.size()); end
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL drain_full got %b expected 0", io_buffer_full); end
    endtask

    task automatic test_rdy_low();
        tx_ready = 1'b1;
        ram_din  = 8'h5A;
        rd_io(32'h00010, 8'h5A);
        mem_a = 32'h00010; mem_wr = 1'b1; rdy_in = 1'b1;
        #1;
        checks++; if (ram_wr !== 1'b1) begin errors++; $display("FAIL ram_wr_ram got %b expected 1", ram_wr); end
        rdy_in = 1'b0;
        #1;
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL ram_wr_rdy_low got %b expected 0", ram_wr); end
        mem_a = 32'h30000; mem_dout = 8'h77;
        #1;
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL ram_wr_io got %b expected 0", ram_wr); end
        step(1);
        mem_wr = 1'b0;
        step(2);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rdy_low_push got %b expected 0", tx_valid); end
        rdy_in = 1'b1;
        rd_io(32'h30007, 8'h00);
        ram_din = 8'hC3; rdy_in = 1'b0; mem_a = 32'h00010;
        step(2);
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rdy_low_hold got %02h expected 00", mem_din); end
        rdy_in = 1'b1;
        step(1);
        checks++; if (mem_din !== 8'hC3) begin errors++; $display("FAIL ram_passthru got %02h expected c3", mem_din); end
        mem_a = 32'h0;
    endtask

    task automatic test_counter();
        tx_ready = 1'b0;
        wr_io(32'h30000, 8'h11);
        wr_io(32'h30000, 8'h12);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b expected 1", tx_valid); end
        rst_in = 1'b0;
        step(1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b expected 0", tx_valid); end
        rst_in = 1'b1;
        step(100);
        rd_io(32'h30004, 8'h64);
        rd_io(32'h30005, 8'h00);
        rd_io(32'h30006, 8'h00);
        rd_io(32'h30007, 8'h00);
        step(300);
        rd_io(32'h30004, 8'h94);
        rd_io(32'h30005, 8'h01);
        rd_io(32'h30006, 8'h00);
        rd_io(32'h30007, 8'h00);
        rd_io(32'h30002, 8'h00);
        step(1);
        checks++; if (rd_q.size() != 0) begin errors++; $display("FAIL rd_left got %0d expected 0", rd_q.size()); end
    endtask

    task automatic test_rx();
        ram_din  = 8'hEE;
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
`ifdef IO_RX_EN
        rd_io(32'h30000, 8'h55);
`else
        rd_io(32'h30000, 8'h00);
`endif
        rd_io(32'h30000, 8'h00);
        step(1);
    endtask

    task automatic test_stop();
        int n;
        tx_ready = 1'b0;
        tx_q.push_back(8'h31); wr_io(32'h30000, 8'h31);
        tx_q.push_back(8'h32); wr_io(32'h30000, 8'h32);
        tx_q.push_back(8'h33); wr_io(32'h30000, 8'h33);
        tx_q.push_back(8'h00); wr_io(32'h30004, 8'hFF);
        step(2);
        checks++; if (program_stop !== 1'b0) begin errors++; $display("FAIL stop_early got %b expected 0", program_stop); end
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid && n < 40) begin
            step(1);
            n++;
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stop_drain_timeout got %b expected 0", tx_valid); end
        checks++; if (program_stop !== 1'b0) begin errors++; $display("FAIL stop_at_empty got %b expected 0", program_stop); end
        step(1);
        checks++; if (program_stop !== 1'b1) begin errors++; $display("FAIL stop_rise got %b expected 1", program_stop); end
        step(5);
        checks++; if (program_stop !== 1'b1) begin errors++; $display("FAIL stop_sticky got %b expected 1", program_stop); end
        checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL stop_left got %0d expected 0", tx_q.size()); end
    endtask

    initial begin
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        mem_a    = 32'h0;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        ram_din  = 8'h3C;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        test_reset();
        test_tx_basic();
        test_full_drop();
        test_rdy_low();
        test_counter();
        test_rx();
        test_stop();
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
